exec_sequencer: RTL and testbench

- Multi-cycle control sequencer for the execution datapath: the regbank, the ALU and the X/Y memory banks.
- Accepts one 32-bit instruction word plus one 32-bit immediate per transaction over a valid/ready handshake.
- Decodes the word into the datapath control bundle (OSD, sel, immediates, ADDR, X/Y, R_W, W_INST/R_INST) and holds that bundle for the required number of cycles.
- Counts the datapath's register-stage latency, then pulses done. It sits between the instruction source and the datapath inputs.

---
 rtl/exec_pkg.sv | 42 ++++
 rtl/lat_counter.sv | 39 +++
 rtl/exec_sequencer.sv | 175 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execution sequencer: instruction classes, FSM states,
// instruction field positions and the default regbank control codes.
// Pure declarations; no logic and no state.
package exec_pkg;

   // Instruction class field encodings
   typedef enum logic [1:0] {
      CLS_ALU   = 2'b00,
      CLS_LOAD  = 2'b01,
      CLS_STORE = 2'b10,
      CLS_NOP   = 2'b11
   } cls_e;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   // Instruction word field positions; OSD is the contiguous {opcode, srcA, srcB, dest}
   localparam int OSD_MSB  = 31;
   localparam int OSD_LSB  = 10;
   localparam int SEL_MSB  = 9;
   localparam int SEL_LSB  = 8;
   localparam int CLS_MSB  = 7;
   localparam int CLS_LSB  = 6;
   localparam int BANK_BIT = 5;

   // Default regbank control codes
   localparam logic [5:0] WB_ALU_CODE_DEF = 6'b000001;
   localparam logic [5:0] WB_MEM_CODE_DEF = 6'b000010;
   localparam logic [5:0] RD_CODE_DEF     = 6'b000001;

   // Latency counter preload: the number of WAIT cycles still to come when ISSUE starts
   function automatic int lat_preload(input cls_e cls, input int exec_lat, input int mem_lat);
      return (cls == CLS_ALU) ? exec_lat - 1 : mem_lat - 1;
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag, used to time datapath latencies.
// Latency: load/decrement visible one cycle later; zero is combinational on the count.
// No backpressure: load wins over decrement, decrement saturates at zero.
module lat_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load has priority, decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer: decodes one instruction into datapath controls and holds them.
// Latency: accept to done = ALU EXEC_LAT+2, LOAD MEM_LAT+2, STORE MEM_LAT+1, NOP 1 cycle.
// Backpressure: inst_ready only in IDLE; inputs are ignored while an instruction is in flight.
module exec_sequencer
   import exec_pkg::*;
#(
   parameter int         DATA_WIDTH  = 32,
   parameter int         EXEC_LAT    = 2,
   parameter int         MEM_LAT     = 3,
   parameter logic [5:0] WB_ALU_CODE = WB_ALU_CODE_DEF,
   parameter logic [5:0] WB_MEM_CODE = WB_MEM_CODE_DEF,
   parameter logic [5:0] RD_CODE     = RD_CODE_DEF,
   parameter int         CNT_W       = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  inst_valid,
   input  logic [31:0]           inst,
   input  logic [DATA_WIDTH-1:0] inst_imm,
   output logic                  inst_ready,
   output logic [21:0]           OSD,
   output logic [1:0]            sel,
   output logic [DATA_WIDTH-1:0] A_imm,
   output logic [DATA_WIDTH-1:0] B_imm,
   output logic [DATA_WIDTH-1:0] ADDR,
   output logic                  X,
   output logic                  Y,
   output logic                  R_W,
   output logic [5:0]            W_INST,
   output logic [5:0]            R_INST,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      retired
);

   localparam int MAX_LAT = (EXEC_LAT > MEM_LAT) ? EXEC_LAT : MEM_LAT;
   localparam int LAT_W   = $clog2(MAX_LAT) + 1;

   state_e                  state_q, state_d;
   logic [31:5]             word_q, word_d;
   logic [DATA_WIDTH-1:0]   imm_q, imm_d;
   logic                    ready_q, ready_d;
   logic [21:0]             osd_q, osd_d;
   logic [1:0]              sel_q, sel_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic                    x_q, x_d, y_q, y_d, r_w_q, r_w_d;
   logic [5:0]              w_inst_q, w_inst_d, r_inst_q, r_inst_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [CNT_W-1:0]        retired_q, retired_d;

   logic                    accept;
   cls_e                    cls;
   logic                    cnt_load, cnt_dec, cnt_zero;
   logic [LAT_W-1:0]        cnt_val;
   logic                    held, is_mem;
   logic                    rsvd_unused;

   // Reserved instruction bits carry no meaning here
   assign rsvd_unused = ^inst[4:0];

   lat_counter #(.W(LAT_W)) u_lat (
      .clk      (CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next state: the counter is preloaded on accept, so ISSUE already sees the remaining wait
   always_comb begin
      accept   = inst_valid && (state_q == ST_IDLE);
      word_d   = accept ? inst[31:5] : word_q;
      imm_d    = accept ? inst_imm : imm_q;
      cls      = cls_e'(word_d[CLS_MSB:CLS_LSB]);
      cnt_val  = LAT_W'(lat_preload(cls, EXEC_LAT, MEM_LAT));
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      state_d  = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_load = 1'b1;
               state_d  = (cls == CLS_NOP) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (cnt_zero) begin
               state_d = (cls == CLS_STORE) ? ST_FIN : ST_WB;
            end else begin
               cnt_dec = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WB:   state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next outputs, decoded from the next state so every control is a flop output
   always_comb begin
      held     = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_WB);
      is_mem   = (cls == CLS_LOAD) || (cls == CLS_STORE);
      osd_d    = held ? word_d[OSD_MSB:OSD_LSB] : '0;
      sel_d    = held ? word_d[SEL_MSB:SEL_LSB] : '0;
      addr_d   = held ? imm_d : '0;
      x_d      = held && is_mem && !word_d[BANK_BIT];
      y_d      = held && is_mem && word_d[BANK_BIT];
      r_w_d    = held && (cls == CLS_LOAD);
      r_inst_d = (held && ((cls == CLS_ALU) || (cls == CLS_STORE))) ? RD_CODE : '0;
      w_inst_d = '0;
      if (state_d == ST_WB) begin
         w_inst_d = (cls == CLS_ALU) ? WB_ALU_CODE : WB_MEM_CODE;
      end
      // busy already drops in FIN, together with the other datapath controls
      busy_d    = held;
      done_d    = (state_d == ST_FIN);
      ready_d   = (state_d == ST_IDLE);
      retired_d = retired_q + CNT_W'(done_d);
   end

   // State, instruction latch and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         word_q    <= '0;
         imm_q     <= '0;
         ready_q   <= 1'b1;
         osd_q     <= '0;
         sel_q     <= '0;
         addr_q    <= '0;
         x_q       <= 1'b0;
         y_q       <= 1'b0;
         r_w_q     <= 1'b0;
         w_inst_q  <= '0;
         r_inst_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         imm_q     <= imm_d;
         ready_q   <= ready_d;
         osd_q     <= osd_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         r_w_q     <= r_w_d;
         w_inst_q  <= w_inst_d;
         r_inst_q  <= r_inst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         retired_q <= retired_d;
      end
   end

   assign inst_ready = ready_q;
   assign OSD        = osd_q;
   assign sel        = sel_q;
   assign A_imm      = addr_q;
   assign B_imm      = addr_q;
   assign ADDR       = addr_q;
   assign X          = x_q;
   assign Y          = y_q;
   assign R_W        = r_w_q;
   assign W_INST     = w_inst_q;
   assign R_INST     = r_inst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: timeline reference model compared every cycle, plus directed
// literal checks for reset, ALU/LOAD/STORE/NOP timing, back-to-back accepts and counter wrap.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_exec_sequencer;

   localparam int DW = 32;
   localparam int EL = 2;
   localparam int ML = 3;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [DW-1:0] inst_imm;
   logic          inst_ready;
   logic [21:0]   OSD;
   logic [1:0]    sel;
   logic [DW-1:0] A_imm, B_imm, ADDR;
   logic          X, Y, R_W;
   logic [5:0]    W_INST, R_INST;
   logic          busy, done;
   logic [CW-1:0] retired;

   always #5 CLK = ~CLK;

   exec_sequencer #(.DATA_WIDTH(DW), .EXEC_LAT(EL), .MEM_LAT(ML), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .inst_valid(inst_valid), .inst(inst), .inst_imm(inst_imm),
      .inst_ready(inst_ready), .OSD(OSD), .sel(sel), .A_imm(A_imm), .B_imm(B_imm),
      .ADDR(ADDR), .X(X), .Y(Y), .R_W(R_W), .W_INST(W_INST), .R_INST(R_INST),
      .busy(busy), .done(done), .retired(retired)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
   endtask

   // Reference model: position k (1..tot) inside the current instruction's timeline
   int          m_tot = 0;
   int          m_k   = 0;
   int          m_ret = 0;
   logic [31:0] m_word = '0;
   logic [31:0] m_imm  = '0;

   function automatic int tot_for(input logic [1:0] c);
      case (c)
         2'b00:   return EL + 2;
         2'b01:   return ML + 2;
         2'b10:   return ML + 1;
         default: return 1;
      endcase
   endfunction

   function automatic logic [159:0] expect_vec();
      logic rdy, bsy, dn, x, y, rw;
      logic [21:0] osd;
      logic [1:0] sl, c;
      logic [31:0] im;
      logic [5:0] w, r;
      logic [CW-1:0] rt;
      rdy = 0; bsy = 0; dn = 0; x = 0; y = 0; rw = 0;
      osd = '0; sl = '0; im = '0; w = '0; r = '0;
      c  = m_word[7:6];
      rt = m_ret[CW-1:0];
      if (m_tot == 0) begin
         rdy = 1;
      end else if (m_k == m_tot) begin
         dn = 1;
      end else begin
         bsy = 1;
         osd = m_word[31:10];
         sl  = m_word[9:8];
         im  = m_imm;
         if (c == 2'b01 || c == 2'b10) begin
            x  = !m_word[5];
            y  = m_word[5];
            rw = (c == 2'b01);
         end
         if (c == 2'b00 || c == 2'b10) r = 6'b000001;
         if ((c == 2'b00 || c == 2'b01) && m_k == m_tot - 1)
            w = (c == 2'b00) ? 6'b000001 : 6'b000010;
      end
      return {rdy, osd, sl, im, im, im, x, y, rw, w, r, bsy, dn, rt, 18'd0};
   endfunction

   function automatic logic [159:0] dut_vec();
      return {inst_ready, OSD, sel, A_imm, B_imm, ADDR, X, Y, R_W, W_INST, R_INST,
              busy, done, retired, 18'd0};
   endfunction

   // Advance the model on every rising edge from the sampled inputs
   initial begin
      forever begin
         @(posedge CLK);
         if (RST) begin
            m_tot = 0; m_k = 0; m_ret = 0;
         end else if (m_tot == 0) begin
            if (inst_valid) begin
               m_word = inst;
               m_imm  = inst_imm;
               m_tot  = tot_for(inst[7:6]);
               m_k    = 1;
               if (m_tot == 1) m_ret = (m_ret + 1) % (1 << CW);
            end
         end else if (m_k == m_tot) begin
            m_tot = 0; m_k = 0;
         end else begin
            m_k++;
            if (m_k == m_tot) m_ret = (m_ret + 1) % (1 << CW);
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge CLK);
         if (chk_en) check("cycle_outputs", dut_vec(), expect_vec());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   typedef struct packed {
      logic [21:0] osd;
      logic [5:0]  r;
      logic        x, y, rw;
      logic [31:0] addr;
   } first_t;

   // Present one instruction (called on a falling edge) and watch it until done
   task automatic send_watch(input logic [31:0] w, input logic [31:0] im, input bit drop_valid,
                             output int lat, output int w_cnt, output logic [5:0] w_val,
                             output int xy_cnt, output first_t first);
      int guard;
      inst = w; inst_imm = im; inst_valid = 1'b1;
      guard = 0;
      while (inst_ready !== 1'b1 && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check("accept_in_time", 160'(guard < 50), 160'(1));
      @(negedge CLK);
      if (drop_valid) inst_valid = 1'b0;
      first = '{osd: OSD, r: R_INST, x: X, y: Y, rw: R_W, addr: ADDR};
      lat = 1; w_cnt = 0; w_val = '0; xy_cnt = 0;
      while (done !== 1'b1 && lat < 50) begin
         if (W_INST != 0) begin w_cnt++; w_val = W_INST; end
         if ((X | Y) && ADDR == im) xy_cnt++;
         @(negedge CLK);
         lat++;
      end
      if (W_INST != 0) w_cnt++;
   endtask

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] d, input logic [1:0] s, input logic [1:0] c,
                                      input logic bank);
      return {op, a, b, d, s, c, bank, 5'b0};
   endfunction

   int          lat, wc, xyc, dones;
   logic [5:0]  wv;
   first_t      f;
   logic [31:0] nop_w;

   initial begin
      RST = 1'b1; inst_valid = 1'b0; inst = '0; inst_imm = '0;
      nop_w = mk(4'h0, 6'd0, 6'd0, 6'd0, 2'd0, 2'b11, 1'b0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      chk_en = 1'b1;
      check("reset_ready", 160'(inst_ready), 160'(1));
      check("reset_busy", 160'(busy), 160'(0));
      check("reset_retired", 160'(retired), 160'(0));
      check("reset_ctrl", {OSD, ADDR, X, Y, R_W, W_INST, R_INST, done}, 160'(0));

      // ALU: opcode 2, srcA 1, srcB 2, dest 3 -> OSD 22'h081083
      send_watch(mk(4'h2, 6'd1, 6'd2, 6'd3, 2'd0, 2'b00, 1'b0), 32'h0, 1, lat, wc, wv, xyc, f);
      check("alu_latency", 160'(lat), 160'(4));
      check("alu_osd", 160'(f.osd), 160'(22'h081083));
      check("alu_rinst", 160'(f.r), 160'(1));
      check("alu_winst_cycles", 160'(wc), 160'(1));
      check("alu_winst_val", 160'(wv), 160'(6'b000001));

      // LOAD from bank Y at 0x10
      @(negedge CLK);
      send_watch(mk(4'h5, 6'd4, 6'd0, 6'd7, 2'd1, 2'b01, 1'b1), 32'h10, 1, lat, wc, wv, xyc, f);
      check("load_latency", 160'(lat), 160'(5));
      check("load_xyrw", 160'({f.x, f.y, f.rw}), 160'(3'b011));
      check("load_addr", 160'(f.addr), 160'(32'h10));
      check("load_hold_cycles", 160'(xyc), 160'(4));
      check("load_winst_val", 160'(wv), 160'(6'b000010));

      // STORE to bank X at 0x4
      @(negedge CLK);
      send_watch(mk(4'h1, 6'd9, 6'd0, 6'd0, 2'd0, 2'b10, 1'b0), 32'h4, 1, lat, wc, wv, xyc, f);
      check("store_latency", 160'(lat), 160'(4));
      check("store_xyrw", 160'({f.x, f.y, f.rw}), 160'(3'b100));
      check("store_hold_cycles", 160'(xyc), 160'(3));
      check("store_winst_cycles", 160'(wc), 160'(0));
      check("retired_after_three", 160'(retired), 160'(3));

      // Reset held 2 cycles in the WAIT cycle of an ALU instruction
      @(negedge CLK);
      inst = mk(4'h3, 6'd1, 6'd1, 6'd1, 2'd2, 2'b00, 1'b0); inst_imm = 32'h55; inst_valid = 1'b1;
      @(negedge CLK);
      inst_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1; dones = 0;
      repeat (2) begin @(negedge CLK); dones += int'(done); end
      RST = 1'b0;
      check("abort_ready", 160'(inst_ready), 160'(1));
      check("abort_busy", 160'(busy), 160'(0));
      check("abort_retired", 160'(retired), 160'(0));
      check("abort_ctrl", {OSD, ADDR, X, Y, R_W, W_INST, R_INST}, 160'(0));
      repeat (6) begin @(negedge CLK); dones += int'(done); end
      check("abort_no_done", 160'(dones), 160'(0));

      // Back-to-back ALU, NOP, LOAD with inst_valid held high
      send_watch(mk(4'h7, 6'd2, 6'd3, 6'd4, 2'd3, 2'b00, 1'b0), 32'h99, 0, lat, wc, wv, xyc, f);
      check("b2b_alu_latency", 160'(lat), 160'(4));
      send_watch(nop_w, 32'h0, 0, lat, wc, wv, xyc, f);
      check("b2b_nop_latency", 160'(lat), 160'(1));
      send_watch(mk(4'h6, 6'd5, 6'd0, 6'd8, 2'd0, 2'b01, 1'b0), 32'h20, 1, lat, wc, wv, xyc, f);
      check("b2b_load_latency", 160'(lat), 160'(5));
      check("b2b_retired", 160'(retired), 160'(3));

      // Wrap of the 4-bit retired counter after 16 NOPs
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 15; i++) begin
         send_watch(nop_w, $urandom, 1, lat, wc, wv, xyc, f);
         @(negedge CLK);
      end
      check("retired_15", 160'(retired), 160'(15));
      send_watch(nop_w, 32'h0, 1, lat, wc, wv, xyc, f);
      check("retired_wrap", 160'(retired), 160'(0));

      // Randomized traffic with occasional resets, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         RST        = ($urandom_range(0, 299) == 0);
         inst_valid = ($urandom_range(0, 2) != 0);
         inst       = $urandom;
         inst_imm   = $urandom;
      end
      @(negedge CLK);
      RST = 1'b0; inst_valid = 1'b0;
      repeat (10) @(negedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
